// File: rtl/seq_mag_cmp_if.sv
// Handshake/operand bundle for the sequential magnitude comparator.
interface seq_mag_cmp_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
);
    localparam int unsigned NUM = WIDTH / DIGIT;
    localparam int unsigned CW  = $clog2(NUM) + 1;

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             EQ;
    logic             GT;
    logic             LT;
    logic [CW-1:0]    digits;

    // Requester side: issues operands and start, observes results.
    modport master (
        output start, A, B, is_signed,
        input  busy, done, EQ, GT, LT, digits
    );

    // Comparator side.
    modport slave (
        input  start, A, B, is_signed,
        output busy, done, EQ, GT, LT, digits
    );
endinterface

// File: rtl/seq_mag_cmp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early
// exit on the first differing digit. Signed mode flips the operand MSBs so the
// unsigned digit compare yields the two's-complement ordering.
module seq_mag_cmp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    seq_mag_cmp_if.slave  bus
);
    localparam int unsigned NUM = WIDTH / DIGIT;
    localparam int unsigned CW  = $clog2(NUM) + 1;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [CW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;
    logic [CW-1:0]    digits_q;

    logic [DIGIT-1:0] da_c;
    logic [DIGIT-1:0] db_c;

    // Current digit under comparison is always the top of each shift register.
    always_comb begin
        da_c = sa_q[WIDTH-1 -: DIGIT];
        db_c = sb_q[WIDTH-1 -: DIGIT];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            digits_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa_q     <= bus.is_signed ? (bus.A ^ MSB_MASK) : bus.A;
                        sb_q     <= bus.is_signed ? (bus.B ^ MSB_MASK) : bus.B;
                        idx_q    <= '0;
                        eq_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        digits_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    if (da_c != db_c) begin
                        gt_q     <= (da_c > db_c);
                        lt_q     <= (da_c < db_c);
                        digits_q <= idx_q + CW'(1);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (idx_q == LAST_IDX) begin
                        eq_q     <= 1'b1;
                        digits_q <= CW'(NUM);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        sa_q  <= sa_q << DIGIT;
                        sb_q  <= sb_q << DIGIT;
                        idx_q <= idx_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.EQ     = eq_q;
    assign bus.GT     = gt_q;
    assign bus.LT     = lt_q;
    assign bus.digits = digits_q;
endmodule

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
Parametrised, multi-cycle magnitude comparator. It is the successor to the 2-bit combinational EQ/GT comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle.
- Terminates early at the first differing digit.
- Supports unsigned and two's-complement modes.
- Reports EQ/GT/LT through a start/busy/done handshake.

It serves datapaths where a wide single-cycle comparator would miss timing.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits compared per cycle; 1 <= DIGIT <= WIDTH.
NUM (localparam), WIDTH/DIGIT, digits per operand.
CW (localparam), clog2(NUM)+1, width of the digit counter/output.

Ports:
clk  in  1  rising-edge clock, single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
A  in  WIDTH  operand A, captured when start accepted
B  in  WIDTH  operand B, captured when start accepted
is_signed  in  1  1 = two's complement, 0 = unsigned; captured with A/B
busy  out  1  high while comparing
done  out  1  one-cycle pulse; results valid
EQ  out  1  A == B
GT  out  1  A > B
LT  out  1  A < B
digits  out  CW  number of digits examined for the last result (1..NUM)

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, EQ=0, GT=0, LT=0, digits=0.
  - Reset overrides all other inputs.
  - Reset during CMP aborts the operation: no done pulse, results stay 0.
- States: IDLE, CMP, DONE.
- IDLE:
  - start=1 at edge t: latch A/B into shift registers sa/sb and latch is_signed.
  - If is_signed=1, invert the MSB of both latched copies (offset-binary), so the unsigned digit compare gives the signed result.
  - Clear EQ/GT/LT/digits; set idx=0; busy=1; go to CMP.
- CMP, one digit per cycle:
  - Compare the top DIGIT bits of sa vs sb (unsigned).
  - Digits differ: at the next edge set GT or LT, digits=idx+1, busy=0, done=1; go to DONE.
  - Digits equal and idx==NUM-1: at the next edge set EQ=1, digits=NUM, busy=0, done=1; go to DONE.
  - Otherwise: shift sa/sb left by DIGIT, idx+=1, stay in CMP.
- DONE: lasts exactly one cycle (done=1), then IDLE with done=0.
- Latency: first differing digit at index k (0 = MSB) gives done high in the cycle after edge t+k+1. Best case 1 cycle; equal or last-digit difference takes NUM cycles.
- Results hold until the next accepted start. After the first completion, exactly one of EQ/GT/LT is 1.
- start is ignored while in CMP or DONE: no effect on operands, results or timing. A and B may change freely after acceptance.
- Back-to-back operation: earliest next accept is the edge after DONE, i.e. the first IDLE cycle.
- WIDTH==DIGIT degenerates to single-cycle compare; done follows one cycle after accept.

Test Plan:
All cases use WIDTH=8, DIGIT=2, NUM=4.
1. Unsigned early exit: A=8'hA5, B=8'h5A, is_signed=0, start -> GT=1, EQ=0, LT=0, digits=1; done pulses 1 cycle after accept.
2. Full-length equal: A=B=8'hFF, start -> EQ=1, digits=4; busy high 4 cycles; done 4 cycles after accept.
3. Signed vs unsigned: A=8'h80, B=8'h01:
   - is_signed=1 -> LT=1, digits=1.
   - Repeat with is_signed=0 -> GT=1, digits=1.
4. Last-digit difference: A=8'h12, B=8'h13 unsigned -> LT=1, digits=4. Also A=8'hFE, B=8'hFF signed (-2 vs -1) -> LT=1, digits=4.
5. Ignored start: accept A=8'h00, B=8'h00.
   - Pulse start with A=8'hFF, B=8'h00 during CMP and again in the DONE cycle -> result stays EQ=1, digits=4; no second done.
   - Next start in IDLE is accepted normally.
6. Reset mid-operation: A=B=8'h3C, start, assert rst in the 2nd CMP cycle -> next cycle busy=0, EQ/GT/LT=0, digits=0; done never pulses. A fresh start after rst deasserts completes normally with EQ=1.
